// File: rtl/matrix_print_engine.sv
`default_nettype none
// ============================================================================
// Module   : matrix_print_engine
// Brief    : Looks up a stored matrix slot through the matrix manager, reads
//            its elements from BRAM and streams a "<m>x<n>\r\n" header plus
//            every element as decimal text over the UART TX handshake.
// Revision : 1.0 - initial release
// ============================================================================
module matrix_print_engine #(
    parameter int ELEMENT_WIDTH = 8,
    parameter int ADDR_WIDTH    = 9,
    parameter int MAX_DIM       = 5,
    parameter int MAX_SLOTS     = 10,
    parameter int SIGNED_ELEMS  = 1,
    parameter int RD_LATENCY    = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mode_active,
    input  logic                     start,
    input  logic [3:0]               slot,
    output logic                     busy,
    output logic                     done,
    output logic [3:0]               error_code,
    output logic [3:0]               query_slot,
    input  logic                     query_valid,
    input  logic [3:0]               query_m,
    input  logic [3:0]               query_n,
    input  logic [ADDR_WIDTH-1:0]    query_addr,
    output logic                     mem_rd_en,
    output logic [ADDR_WIDTH-1:0]    mem_rd_addr,
    input  logic [ELEMENT_WIDTH-1:0] mem_rd_data,
    output logic [7:0]               tx_data,
    output logic                     tx_start,
    input  logic                     tx_busy
);

    localparam logic [3:0] c_S_IDLE    = 4'd0;
    localparam logic [3:0] c_S_QUERY   = 4'd1;
    localparam logic [3:0] c_S_CHECK   = 4'd2;
    localparam logic [3:0] c_S_HDR     = 4'd3;
    localparam logic [3:0] c_S_RD_REQ  = 4'd4;
    localparam logic [3:0] c_S_RD_WAIT = 4'd5;
    localparam logic [3:0] c_S_CONV    = 4'd6;
    localparam logic [3:0] c_S_EMIT    = 4'd7;
    localparam logic [3:0] c_S_SEP     = 4'd8;
    localparam logic [3:0] c_S_DONE    = 4'd9;
    localparam logic [3:0] c_S_ERR     = 4'd10;

    localparam logic [4:0] c_MAX_SLOTS = 5'(MAX_SLOTS);
    localparam logic [3:0] c_MAX_DIM   = 4'(MAX_DIM);
    localparam logic [1:0] c_RD_LAT    = 2'(RD_LATENCY);

    logic [3:0]               r_state;
    logic [3:0]               r_m;
    logic [3:0]               r_n;
    logic [3:0]               r_row;
    logic [3:0]               r_col;
    logic [ADDR_WIDTH-1:0]    r_addr;
    logic [2:0]               r_idx;
    logic [2:0]               r_len;
    logic [2:0]               r_pow;
    logic [3:0]               r_digit;
    logic                     r_started;
    logic [16:0]              r_mag;
    logic [1:0]               r_wait;
    logic [1:0]               r_tx_gap;
    logic [7:0]               r_buf [0:7];

    logic                     w_tx_ok;
    logic                     w_last_col;
    logic                     w_last_row;
    logic                     w_rd_neg;
    logic [ELEMENT_WIDTH-1:0] w_rd_mag;
    logic [16:0]              w_pow;
    logic [7:0]               w_hdr_byte;
    logic [7:0]               w_sep_byte;

    function automatic logic [16:0] f_pow10(input logic [2:0] i_sel);
        case (i_sel)
            3'd4:    f_pow10 = 17'd10000;
            3'd3:    f_pow10 = 17'd1000;
            3'd2:    f_pow10 = 17'd100;
            3'd1:    f_pow10 = 17'd10;
            default: f_pow10 = 17'd1;
        endcase
    endfunction

    // A strobe may go out only once the gap after the previous strobe has
    // elapsed (so the busy flag right after a strobe is never trusted).
    assign w_tx_ok    = (r_tx_gap == 2'd0) && !tx_busy;
    assign w_last_col = (r_col == r_n - 4'd1);
    assign w_last_row = (r_row == r_m - 4'd1);
    assign w_rd_neg   = (SIGNED_ELEMS != 0) && mem_rd_data[ELEMENT_WIDTH-1];
    // Magnitude in ELEMENT_WIDTH unsigned bits also covers the most-negative value.
    assign w_rd_mag   = w_rd_neg ? ((~mem_rd_data) + {{(ELEMENT_WIDTH-1){1'b0}}, 1'b1})
                                 : mem_rd_data;
    assign w_pow      = f_pow10(r_pow);
    assign w_sep_byte = !w_last_col ? 8'h20 : ((r_idx == 3'd0) ? 8'h0D : 8'h0A);

    // Header byte selected by position within "<m>x<n>\r\n".
    always_comb begin
        w_hdr_byte = 8'h0A;
        case (r_idx)
            3'd0:    w_hdr_byte = 8'h30 + {4'h0, r_m};
            3'd1:    w_hdr_byte = 8'h78;
            3'd2:    w_hdr_byte = 8'h30 + {4'h0, r_n};
            3'd3:    w_hdr_byte = 8'h0D;
            default: w_hdr_byte = 8'h0A;
        endcase
    end

    // Main sequencer: query, validate, header, then read/convert/emit per element.
    always_ff @(posedge clk) begin
        if (rst || !mode_active) begin
            r_state     <= c_S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            error_code  <= 4'd0;
            query_slot  <= 4'd0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            tx_data     <= 8'h00;
            tx_start    <= 1'b0;
            r_m         <= 4'd0;
            r_n         <= 4'd0;
            r_row       <= 4'd0;
            r_col       <= 4'd0;
            r_addr      <= '0;
            r_idx       <= 3'd0;
            r_len       <= 3'd0;
            r_pow       <= 3'd0;
            r_digit     <= 4'd0;
            r_started   <= 1'b0;
            r_mag       <= 17'd0;
            r_wait      <= 2'd0;
            r_tx_gap    <= 2'd0;
            for (int i = 0; i < 8; i++) begin
                r_buf[i] <= 8'h00;
            end
        end else begin
            done      <= 1'b0;
            mem_rd_en <= 1'b0;
            tx_start  <= 1'b0;
            if (r_tx_gap != 2'd0) begin
                r_tx_gap <= r_tx_gap - 2'd1;
            end
            case (r_state)
                c_S_IDLE: begin
                    if (start) begin
                        query_slot <= slot;
                        busy       <= 1'b1;
                        error_code <= 4'd0;
                        r_state    <= c_S_QUERY;
                    end
                end
                c_S_QUERY: begin
                    r_state <= c_S_CHECK;
                end
                c_S_CHECK: begin
                    if (({1'b0, query_slot} >= c_MAX_SLOTS) || !query_valid) begin
                        error_code <= 4'd1;
                        r_state    <= c_S_ERR;
                    end else if ((query_m == 4'd0) || (query_m > c_MAX_DIM) ||
                                 (query_n == 4'd0) || (query_n > c_MAX_DIM)) begin
                        error_code <= 4'd2;
                        r_state    <= c_S_ERR;
                    end else begin
                        r_m     <= query_m;
                        r_n     <= query_n;
                        r_addr  <= query_addr;
                        r_row   <= 4'd0;
                        r_col   <= 4'd0;
                        r_idx   <= 3'd0;
                        r_state <= c_S_HDR;
                    end
                end
                c_S_ERR: begin
                    busy    <= 1'b0;
                    r_state <= c_S_IDLE;
                end
                c_S_HDR: begin
                    if (w_tx_ok) begin
                        tx_start <= 1'b1;
                        tx_data  <= w_hdr_byte;
                        r_tx_gap <= 2'd2;
                        if (r_idx == 3'd4) begin
                            r_idx   <= 3'd0;
                            r_state <= c_S_RD_REQ;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end
                end
                c_S_RD_REQ: begin
                    mem_rd_en   <= 1'b1;
                    mem_rd_addr <= r_addr;
                    r_wait      <= 2'd0;
                    r_state     <= c_S_RD_WAIT;
                end
                c_S_RD_WAIT: begin
                    if (r_wait == c_RD_LAT) begin
                        r_mag     <= {{(17-ELEMENT_WIDTH){1'b0}}, w_rd_mag};
                        r_buf[0]  <= 8'h2D;
                        r_len     <= w_rd_neg ? 3'd1 : 3'd0;
                        r_pow     <= 3'd4;
                        r_digit   <= 4'd0;
                        r_started <= 1'b0;
                        r_state   <= c_S_CONV;
                    end else begin
                        r_wait <= r_wait + 2'd1;
                    end
                end
                c_S_CONV: begin
                    // One subtraction per cycle; a digit is written once the
                    // current power of ten no longer fits.
                    if (r_mag >= w_pow) begin
                        r_mag   <= r_mag - w_pow;
                        r_digit <= r_digit + 4'd1;
                    end else begin
                        if ((r_digit != 4'd0) || r_started || (r_pow == 3'd0)) begin
                            r_buf[r_len] <= 8'h30 + {4'h0, r_digit};
                            r_len        <= r_len + 3'd1;
                            r_started    <= 1'b1;
                        end
                        r_digit <= 4'd0;
                        if (r_pow == 3'd0) begin
                            r_idx   <= 3'd0;
                            r_state <= c_S_EMIT;
                        end else begin
                            r_pow <= r_pow - 3'd1;
                        end
                    end
                end
                c_S_EMIT: begin
                    if (w_tx_ok) begin
                        tx_start <= 1'b1;
                        tx_data  <= r_buf[r_idx];
                        r_tx_gap <= 2'd2;
                        if (r_idx == r_len - 3'd1) begin
                            r_idx   <= 3'd0;
                            r_state <= c_S_SEP;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end
                end
                c_S_SEP: begin
                    if (w_tx_ok) begin
                        tx_start <= 1'b1;
                        tx_data  <= w_sep_byte;
                        r_tx_gap <= 2'd2;
                        if (!w_last_col || (r_idx == 3'd1)) begin
                            r_idx <= 3'd0;
                            if (w_last_col && w_last_row) begin
                                r_state <= c_S_DONE;
                            end else begin
                                r_addr <= r_addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                                if (w_last_col) begin
                                    r_col <= 4'd0;
                                    r_row <= r_row + 4'd1;
                                end else begin
                                    r_col <= r_col + 4'd1;
                                end
                                r_state <= c_S_RD_REQ;
                            end
                        end else begin
                            r_idx <= 3'd1;
                        end
                    end
                end
                c_S_DONE: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= c_S_IDLE;
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_matrix_print_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_print_engine
// Brief    : Self-checking bench for matrix_print_engine. A signed and an
//            unsigned instance share the slot table and BRAM contents; the
//            expected byte streams come from a string-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_print_engine;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mode_active = 1'b0;
    logic start = 1'b0;
    logic [3:0] slot = 4'd0;

    logic       busy1, done1, qv1, rd_en1, txs1, txb1;
    logic [3:0] err1, qs1, qm1, qn1;
    logic [8:0] qa1, rd_addr1;
    logic [7:0] rd_data1, txd1;
    logic       busy2, done2, qv2, rd_en2, txs2, txb2;
    logic [3:0] err2, qs2, qm2, qn2;
    logic [8:0] qa2, rd_addr2;
    logic [7:0] rd_data2, txd2;

    logic [7:0] mem [0:511];
    logic       tv [0:15];
    logic [3:0] tm [0:15];
    logic [3:0] tn [0:15];
    logic [8:0] ta [0:15];

    int n_cmp = 0;
    int n_bad = 0;
    int busy_len1 = 0;
    int cnt1 = 0;
    int cnt2 = 0;
    logic       p1_v = 1'b0, p2_v = 1'b0;
    logic [8:0] p1_a = '0, p2_a = '0;
    logic [7:0] junk1 = 8'h00, junk2 = 8'h00;

    logic [7:0] exp_b1 [$];
    logic [7:0] exp_b2 [$];
    logic [8:0] exp_a1 [$];
    string got1 = "";
    string got2 = "";
    int cyc = 0;
    int last_tx1 = -10;
    int ntx1 = 0, ntx2 = 0, done_cnt1 = 0, done_cnt2 = 0, n_rd1 = 0;
    logic prev_en1 = 1'b0;

    always #5 clk = ~clk;

    matrix_print_engine u_dut (
        .clk(clk), .rst(rst), .mode_active(mode_active), .start(start), .slot(slot),
        .busy(busy1), .done(done1), .error_code(err1), .query_slot(qs1),
        .query_valid(qv1), .query_m(qm1), .query_n(qn1), .query_addr(qa1),
        .mem_rd_en(rd_en1), .mem_rd_addr(rd_addr1), .mem_rd_data(rd_data1),
        .tx_data(txd1), .tx_start(txs1), .tx_busy(txb1)
    );

    matrix_print_engine #(.SIGNED_ELEMS(0)) u_dut_uns (
        .clk(clk), .rst(rst), .mode_active(mode_active), .start(start), .slot(slot),
        .busy(busy2), .done(done2), .error_code(err2), .query_slot(qs2),
        .query_valid(qv2), .query_m(qm2), .query_n(qn2), .query_addr(qa2),
        .mem_rd_en(rd_en2), .mem_rd_addr(rd_addr2), .mem_rd_data(rd_data2),
        .tx_data(txd2), .tx_start(txs2), .tx_busy(txb2)
    );

    // Matrix manager: combinational table lookup on the presented slot.
    assign qv1 = tv[qs1];
    assign qm1 = tm[qs1];
    assign qn1 = tn[qs1];
    assign qa1 = ta[qs1];
    assign qv2 = tv[qs2];
    assign qm2 = tm[qs2];
    assign qn2 = tn[qs2];
    assign qa2 = ta[qs2];

    // BRAM with one cycle of latency; junk outside the valid data cycle.
    always @(posedge clk) begin
        p1_v  <= rd_en1;
        p1_a  <= rd_addr1;
        junk1 <= 8'($urandom);
        p2_v  <= rd_en2;
        p2_a  <= rd_addr2;
        junk2 <= 8'($urandom);
    end
    assign rd_data1 = p1_v ? mem[p1_a] : junk1;
    assign rd_data2 = p2_v ? mem[p2_a] : junk2;

    // UART transmitters: busy for a programmable number of cycles after a strobe.
    always @(posedge clk) begin
        if (txs1) cnt1 <= busy_len1;
        else if (cnt1 > 0) cnt1 <= cnt1 - 1;
        if (txs2) cnt2 <= 2;
        else if (cnt2 > 0) cnt2 <= cnt2 - 1;
    end
    assign txb1 = (cnt1 != 0);
    assign txb2 = (cnt2 != 0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic string esc(input string s);
        string r = "";
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == 8'h0D) r = {r, "\\r"};
            else if (s[i] == 8'h0A) r = {r, "\\n"};
            else r = {r, $sformatf("%c", s[i])};
        end
        return r;
    endfunction

    task automatic chk_str(input string name, input string act, input string exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got \"%s\", expected \"%s\"", name, esc(act), esc(exp));
        end
    endtask

    // Reference text of a slot: header, decimal elements, separators, CRLF per row.
    function automatic string model_str(input int s, input bit sgn);
        int m = int'(tm[s]);
        int n = int'(tn[s]);
        string r = $sformatf("%0dx%0d\r\n", m, n);
        for (int row = 0; row < m; row++) begin
            for (int col = 0; col < n; col++) begin
                logic [7:0] v = mem[(int'(ta[s]) + row * n + col) % 512];
                int val;
                if (sgn) val = int'($signed(v));
                else val = int'(v);
                r = {r, $sformatf("%0d", val), (col == n - 1) ? "\r\n" : " "};
            end
        end
        return r;
    endfunction

    task automatic build(input int s);
        string s1 = model_str(s, 1'b1);
        string s2 = model_str(s, 1'b0);
        exp_b1.delete();
        exp_b2.delete();
        exp_a1.delete();
        for (int i = 0; i < s1.len(); i++) exp_b1.push_back(s1[i]);
        for (int i = 0; i < s2.len(); i++) exp_b2.push_back(s2[i]);
        for (int k = 0; k < int'(tm[s]) * int'(tn[s]); k++)
            exp_a1.push_back(9'((int'(ta[s]) + k) % 512));
    endtask

    // Per-cycle checker: byte stream, address sequence and handshake rules.
    always @(negedge clk) begin
        cyc++;
        if (txs1) begin
            ntx1++;
            chk("tx1_busy_clear", {31'd0, txb1}, 32'd0);
            chk("tx1_spacing_ok", {31'd0, (cyc - last_tx1) >= 3}, 32'd1);
            last_tx1 = cyc;
            got1 = {got1, $sformatf("%c", txd1)};
            if (exp_b1.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL tx1_extra_byte: got %0h, expected no byte", txd1);
            end else begin
                chk("tx1_byte", {24'd0, txd1}, {24'd0, exp_b1.pop_front()});
            end
        end
        if (rd_en1) begin
            n_rd1++;
            chk("rd1_not_back_to_back", {31'd0, prev_en1}, 32'd0);
            if (exp_a1.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rd1_extra_read: got %0h, expected no read", rd_addr1);
            end else begin
                chk("rd1_addr", {23'd0, rd_addr1}, {23'd0, exp_a1.pop_front()});
            end
        end
        prev_en1 = rd_en1;
        if (done1) begin
            done_cnt1++;
            chk("done1_all_bytes_sent", exp_b1.size(), 32'd0);
            chk("done1_busy_low", {31'd0, busy1}, 32'd0);
        end
        if (txs2) begin
            ntx2++;
            got2 = {got2, $sformatf("%c", txd2)};
            if (exp_b2.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL tx2_extra_byte: got %0h, expected no byte", txd2);
            end else begin
                chk("tx2_byte", {24'd0, txd2}, {24'd0, exp_b2.pop_front()});
            end
        end
        if (done2) done_cnt2++;
    end

    task automatic run(input int s, input int blen, input logic [3:0] exp_err, input bit inject);
        int w = 1;
        int lat1 = 0;
        @(negedge clk);
        busy_len1 = blen;
        if (exp_err == 4'd0) build(s);
        else begin
            exp_b1.delete();
            exp_b2.delete();
            exp_a1.delete();
        end
        got1 = "";
        got2 = "";
        ntx1 = 0;
        ntx2 = 0;
        done_cnt1 = 0;
        done_cnt2 = 0;
        slot = 4'(s);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy1_after_start", {31'd0, busy1}, 32'd1);
        chk("busy2_after_start", {31'd0, busy2}, 32'd1);
        chk("query_slot1", {28'd0, qs1}, 32'(s));
        while ((busy1 || busy2) && w < 20000) begin
            if (inject && w == 100) begin
                slot = 4'd12;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            w++;
            if (!busy1 && lat1 == 0) lat1 = w;
        end
        start = 1'b0;
        if (w >= 20000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL run_timeout: slot %0d still busy after %0d cycles", s, w);
        end
        @(negedge clk);
        chk("err1", {28'd0, err1}, {28'd0, exp_err});
        chk("err2", {28'd0, err2}, {28'd0, exp_err});
        if (exp_err == 4'd0) begin
            chk("done1_count", done_cnt1, 32'd1);
            chk("done2_count", done_cnt2, 32'd1);
            chk("bytes1_left", exp_b1.size(), 32'd0);
            chk("bytes2_left", exp_b2.size(), 32'd0);
            chk("reads1_left", exp_a1.size(), 32'd0);
        end else begin
            chk("err_tx1_count", ntx1, 32'd0);
            chk("err_tx2_count", ntx2, 32'd0);
            chk("err_done1_count", done_cnt1, 32'd0);
            chk("err_busy_low_within_4", {31'd0, lat1 <= 4}, 32'd1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 16; i++) begin
            tv[i] = 1'b0; tm[i] = 4'd1; tn[i] = 4'd1; ta[i] = 9'd0;
        end
        tv[0] = 1'b1; tm[0] = 4'd2; tn[0] = 4'd2; ta[0] = 9'd100;
        mem[100] = 8'h01; mem[101] = 8'hFE; mem[102] = 8'h1E; mem[103] = 8'h00;
        tv[1] = 1'b1; tm[1] = 4'd1; tn[1] = 4'd1; ta[1] = 9'd20;
        mem[20] = 8'h80;
        tv[2] = 1'b1; tm[2] = 4'd3; tn[2] = 4'd3; ta[2] = 9'd508;
        mem[508] = 8'h7F; mem[509] = 8'hFF; mem[510] = 8'h00; mem[511] = 8'h05;
        mem[0] = 8'h9C; mem[1] = 8'h63; mem[2] = 8'h0A; mem[3] = 8'hF6; mem[4] = 8'h40;
        tv[3] = 1'b0; tm[3] = 4'd2; tn[3] = 4'd2;
        tv[4] = 1'b1; tm[4] = 4'd0; tn[4] = 4'd3;
        tv[5] = 1'b1; tm[5] = 4'd7; tn[5] = 4'd1;
        tv[6] = 1'b1; tm[6] = 4'd2; tn[6] = 4'd6;
        tv[7] = 1'b1; tm[7] = 4'd5; tn[7] = 4'd5; ta[7] = 9'd200;
        tv[9] = 1'b1; tm[9] = 4'd1; tn[9] = 4'd3; ta[9] = 9'd300;
        mem[300] = 8'h09; mem[301] = 8'h81; mem[302] = 8'h64;
        tv[12] = 1'b1; tm[12] = 4'd1; tn[12] = 4'd1; ta[12] = 9'd20;

        // Reset state
        rst = 1'b1;
        mode_active = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy1}, 32'd0);
        chk("rst_done", {31'd0, done1}, 32'd0);
        chk("rst_err", {28'd0, err1}, 32'd0);
        chk("rst_query_slot", {28'd0, qs1}, 32'd0);
        chk("rst_rd_en", {31'd0, rd_en1}, 32'd0);
        chk("rst_rd_addr", {23'd0, rd_addr1}, 32'd0);
        chk("rst_tx_data", {24'd0, txd1}, 32'd0);
        chk("rst_tx_start", {31'd0, txs1}, 32'd0);
        rst = 1'b0;

        // Pin the model with hand-derived text
        chk_str("model_slot0", model_str(0, 1'b1), "2x2\r\n1 -2\r\n30 0\r\n");
        chk_str("model_neg128", model_str(1, 1'b1), "1x1\r\n-128\r\n");
        chk_str("model_uns128", model_str(1, 1'b0), "1x1\r\n128\r\n");

        run(0, 0, 4'd0, 1'b0);
        chk_str("slot0_signed", got1, "2x2\r\n1 -2\r\n30 0\r\n");
        chk_str("slot0_unsigned", got2, "2x2\r\n1 254\r\n30 0\r\n");
        run(1, 0, 4'd0, 1'b0);
        chk_str("neg128_signed", got1, "1x1\r\n-128\r\n");
        chk_str("neg128_unsigned", got2, "1x1\r\n128\r\n");

        run(12, 0, 4'd1, 1'b0);
        run(3, 0, 4'd1, 1'b0);
        run(4, 0, 4'd2, 1'b0);
        run(5, 0, 4'd2, 1'b0);
        run(6, 0, 4'd2, 1'b0);

        // Slow UART plus a start pulse that must be ignored while busy
        run(0, 50, 4'd0, 1'b1);
        chk_str("slow_uart_slot0", got1, "2x2\r\n1 -2\r\n30 0\r\n");

        run(7, 0, 4'd0, 1'b0);
        run(9, 0, 4'd0, 1'b0);
        chk_str("slot9_signed", got1, "1x3\r\n9 -127 100\r\n");
        run(2, 0, 4'd0, 1'b0);
        chk_str("wrap_3x3", got1, "3x3\r\n127 -1 0\r\n5 -100 99\r\n10 -10 64\r\n");

        // Abort in the middle of an element, then print the full matrix again
        @(negedge clk);
        build(2);
        n_rd1 = 0;
        slot = 4'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (n_rd1 < 4 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 2000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL abort_wait: only %0d reads seen", n_rd1);
        end
        @(negedge clk);
        mode_active = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy1}, 32'd0);
        chk("abort_query_slot", {28'd0, qs1}, 32'd0);
        chk("abort_rd_addr", {23'd0, rd_addr1}, 32'd0);
        chk("abort_tx_data", {24'd0, txd1}, 32'd0);
        chk("abort_tx_start", {31'd0, txs1}, 32'd0);
        chk("abort_busy2", {31'd0, busy2}, 32'd0);
        mode_active = 1'b1;
        run(2, 0, 4'd0, 1'b0);
        chk_str("restart_3x3", got1, "3x3\r\n127 -1 0\r\n5 -100 99\r\n10 -10 64\r\n");

        // start coinciding with mode_active low: the abort wins
        @(negedge clk);
        slot = 4'd0;
        start = 1'b1;
        mode_active = 1'b0;
        @(negedge clk);
        chk("start_vs_abort_busy1", {31'd0, busy1}, 32'd0);
        chk("start_vs_abort_busy2", {31'd0, busy2}, 32'd0);
        start = 1'b0;
        mode_active = 1'b1;
        @(negedge clk);
        chk("start_vs_abort_idle", {31'd0, busy1}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
